chaos_word_handoff_ctrl: RTL

//  Sequences hand-off of 8-bit chaos words from the chaos generator core into the
//  pio_chaos_w input PIO, one word at a time. The PIO synchronises in_port through
//  two flops and latches rising edges, so this block:
//   - holds each word stable on pio_data before raising pio_flag (flag feeds an edge-capture PIO bit);
//   - holds the flag until the Nios acknowledges by writing the edge-capture register;
//   - recovers by timeout if no acknowledge arrives.

---
 rtl/chaos_pio_pkg.sv | 26 ++
 rtl/hs_down_counter.sv | 27 ++
 rtl/chaos_word_handoff_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/chaos_pio_pkg.sv
// rtl/chaos_pio_pkg.sv - shared states, defaults and helpers for the chaos word PIO hand-off
package chaos_pio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FLAG  = 2'd2,
    ST_LOW   = 2'd3
  } hs_state_t;

  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_MIN_LOW_CYC = 2;
  localparam int DEF_ACK_TIMEOUT = 1000000;

  // Nios write to this PIO offset clears edge capture and is decoded outside as cpu_ack
  localparam logic [1:0] PIO_EDGE_CAP_ADDR = 2'd3;

  function automatic int hs_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hs_down_counter.sv
// rtl/hs_down_counter.sv - loadable down-counter with zero flag, shared by all hand-off phases
module hs_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/chaos_word_handoff_ctrl.sv
// rtl/chaos_word_handoff_ctrl.sv - hands chaos words to an edge-capture PIO with setup, ack and timeout
module chaos_word_handoff_ctrl
  import chaos_pio_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int MIN_LOW_CYC = DEF_MIN_LOW_CYC,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              cpu_ack,
  output logic [DATA_W-1:0] pio_data,
  output logic              pio_flag,
  output logic              busy,
  output logic              timeout_pls,
  output logic [CNT_W-1:0]  timeout_cnt
);

  localparam int CW = hs_cnt_width(ACK_TIMEOUT, SETUP_CYC, MIN_LOW_CYC);
  localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_FLAG  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] LD_LOW   = CW'(MIN_LOW_CYC - 1);

  hs_state_t     state;
  logic          accept;
  logic          zero;
  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] cnt_val;

  assign accept = (state == ST_IDLE) && s_valid && s_ready;
  assign busy   = (state != ST_IDLE);

  // The single counter is reloaded on every phase change with that phase's length minus one
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = LD_SETUP;
    case (state)
      ST_IDLE: begin
        cnt_load = accept;
      end
      ST_SETUP: begin
        cnt_load = zero;
        cnt_val  = LD_FLAG;
        cnt_dec  = !zero;
      end
      ST_FLAG: begin
        cnt_load = cpu_ack || zero;
        cnt_val  = LD_LOW;
        cnt_dec  = !(cpu_ack || zero);
      end
      ST_LOW: begin
        cnt_dec  = !zero;
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  hs_down_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      s_ready     <= 1'b0;
      pio_data    <= '0;
      pio_flag    <= 1'b0;
      timeout_pls <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      timeout_pls <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pio_data <= s_data;
            s_ready  <= 1'b0;
            state    <= ST_SETUP;
          end else begin
            s_ready  <= enable;
          end
        end
        ST_SETUP: begin
          // an ack seen here belongs to an earlier word and is deliberately ignored
          if (zero) begin
            pio_flag <= 1'b1;
            state    <= ST_FLAG;
          end
        end
        ST_FLAG: begin
          if (cpu_ack) begin
            pio_flag <= 1'b0;
            state    <= ST_LOW;
          end else if (zero) begin
            pio_flag    <= 1'b0;
            timeout_pls <= 1'b1;
            if (timeout_cnt != '1) timeout_cnt <= timeout_cnt + CNT_W'(1);
            state       <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (zero) begin
            state   <= ST_IDLE;
            s_ready <= enable;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
